clk_div_gen: RTL
================

# clk_div_gen

Programmable integer clock divider that generates `clkdiv` and `bypass` for the glitch-free output clock mux in the programmable frequency divider. It runs entirely on `clkin` and divides it by a runtime-loadable ratio N. Ratio changes take effect only at a divided-period boundary, so the mux never sees a truncated high or low phase. A ratio of 1 requests bypass, and `clkdiv` is held low.

## Interface
- `WIDTH`, 8: width of the ratio, counter and active-ratio bus; N ranges 0..2^WIDTH-1.
- `RESET_RATIO`, 2: ratio in effect after reset; must be ≥ 1 and < 2^WIDTH.
- `clkin`  input  1  only clock; all logic is posedge except the half-cycle stage under `CLK_DIV_ODD_DUTY50_EN`.
- `rst_n`  input  1  asynchronous, active-low reset.
- `div_ratio`  input  WIDTH  requested ratio N; 0 is treated as 1.
- `div_load`  input  1  sampled every posedge; when high and `div_busy`=0, requests a load of `div_ratio`.
- `div_busy`  output  1  accepted ratio is pending and not yet applied.
- `div_active`  output  WIDTH  ratio currently applied; 0 is reported as 1.
- `clkdiv`  output  1  divided clock, driven from flops with no combinational path to output.
- `bypass`  output  1  high while `div_active`=1; drives the output mux select.
- `period_start`  output  1  high during the `clkin` cycle in which `clkdiv` rises; held high while in bypass.

## Operation
- Counter `cnt` (WIDTH bits) counts 0..N-1 and wraps to 0. The edge that moves `cnt` from N-1 to 0 is the boundary edge.
- H = N>>1. For N ≥ 2, `clkdiv` is high during the cycles where `cnt` is 0..H-1 and low for the rest of the period.
- Even N gives a 50% duty cycle. Odd N gives H cycles high and H+1 cycles low, unless the macro below is defined.
- N = 1 (or 0): `bypass`=1, `clkdiv`=0, `cnt` held at 0, and every edge is a boundary edge.
- Load handshake:
  - `div_load`=1 with `div_busy`=0 captures `div_ratio` into the pending register and sets `div_busy`=1.
  - `div_load` is ignored while `div_busy`=1; it is dropped, not queued.
- Apply:
  - On a boundary edge, the pending ratio moves to `div_active`, `div_busy` clears and `cnt` becomes 0.
  - The new period starts with `clkdiv` high (N ≥ 2) or in bypass (N = 1).
- Simultaneous load and boundary: if `div_load` is accepted on a boundary edge, the new ratio is applied on that same edge and `div_busy` never rises.
- In bypass, every load is therefore applied on the accepting edge.
- Leaving bypass: the first edge gives `cnt`=0, `clkdiv`=1 and `bypass`=0 together.
- Entering bypass: `clkdiv` is already low at the boundary (the last cycle of a period is always in the low phase) and stays low.

## Timing
- Reset values:
  - `clkdiv`=0, `period_start`=0, `div_busy`=0.
  - `div_active`=RESET_RATIO, `bypass`=(RESET_RATIO==1).
  - `cnt`=RESET_RATIO-1 (end of period); the pending register is cleared.
- The first posedge after `rst_n` deasserts is a boundary edge: `clkdiv` rises, or bypass holds.
- `rst_n` assertion mid-operation forces all reset values immediately and asynchronously. A pending load is lost.
- Load latency: at most N_old edges from acceptance to application, and at least 0 edges (boundary coincident with acceptance).
- All outputs change only on posedge `clkin`, except the `clkdiv` falling edge under the macro.

## Configuration
- `CLK_DIV_ODD_DUTY50_EN` defined:
  - For odd N ≥ 3, add a negedge-`clkin` flop that samples the posedge `clkdiv` term.
  - `clkdiv` is the OR of the two flops, so it is high for H+0.5 `clkin` cycles: 50% duty, falling on a negedge.
  - Even N and bypass are unchanged; the negedge flop is forced low for them.
  - The negedge flop resets to 0.
- Not defined: the design uses posedge logic only, and odd N gives the H-high / H+1-low duty cycle.

## Test plan
- Reset with RESET_RATIO=2 and no loads → `clkdiv` pattern 1,0,1,0 from the first edge, `period_start` every 2nd cycle, `bypass`=0, `div_active`=2.
- At N=2, load 6 mid-period → `div_busy`=1 until the next boundary, then `div_busy`=0, `div_active`=6, `clkdiv` high 3 / low 3.
- Load 5 → without the macro, `clkdiv` high 2 / low 3 cycles. With the macro, `clkdiv` rises on a posedge and falls on the negedge within the 3rd cycle (2.5 high / 2.5 low).
- Load 1 → at the boundary, `bypass`=1, `clkdiv` stays 0, `period_start` held 1. Then load 4 → on the next edge, `bypass`=0, `clkdiv` high 2 / low 2, `div_busy` never 1.
- Load 0 → `div_active` reads 1 and `bypass`=1. Load 3 while `div_busy`=1 with 6 pending → only 6 is applied and 3 is dropped.
- Assert `rst_n` low mid high-phase at N=6 → `clkdiv`=0 and `div_busy`=0 immediately. After release, the first edge gives `clkdiv`=1 with `div_active`=RESET_RATIO.

Source files
------------

// File: rtl/clk_div_gen_if.sv
// clk_div_gen_if: ratio load handshake and divided-clock outputs
// shared between the divider and its controller / output mux.
interface clk_div_gen_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] div_ratio;
  logic             div_load;
  logic             div_busy;
  logic [WIDTH-1:0] div_active;
  logic             clkdiv;
  logic             bypass;
  logic             period_start;

  modport master (
    output div_ratio,
    output div_load,
    input  div_busy,
    input  div_active,
    input  clkdiv,
    input  bypass,
    input  period_start
  );

  modport slave (
    input  div_ratio,
    input  div_load,
    output div_busy,
    output div_active,
    output clkdiv,
    output bypass,
    output period_start
  );
endinterface

// File: rtl/clk_div_gen.sv
// clk_div_gen: programmable integer divider, ratio applied on period boundary.
// Optional CLK_DIV_ODD_DUTY50_EN adds a negedge stage for 50% duty on odd N.
module clk_div_gen #(
  parameter int WIDTH       = 8,
  parameter int RESET_RATIO = 2
) (
  input  logic        clkin,
  input  logic        rst_n,
  clk_div_gen_if.slave div_if
);

  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_N  = WIDTH'(RESET_RATIO);
  localparam logic [WIDTH-1:0] RST_CN = WIDTH'(RESET_RATIO - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_q, act_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             clkdiv_q, clkdiv_d;
  logic             pstart_q, pstart_d;
  logic             bypass_q, bypass_d;

  logic [WIDTH-1:0] ratio_eff;
  logic             accept;
  logic             boundary;

  assign ratio_eff = (div_if.div_ratio == '0) ? ONE : div_if.div_ratio;
  assign accept    = div_if.div_load & ~busy_q;
  assign boundary  = (cnt_q == act_q - ONE);

  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    pend_d = pend_q;
    busy_d = busy_q;
    if (boundary) begin
      cnt_d  = '0;
      busy_d = 1'b0;
      if (accept)
        act_d = ratio_eff;
      else if (busy_q)
        act_d = pend_q;
    end else begin
      cnt_d = cnt_q + ONE;
      if (accept) begin
        pend_d = ratio_eff;
        busy_d = 1'b1;
      end
    end
    // high phase is cnt 0..H-1; H is 0 in bypass
    clkdiv_d = (cnt_d < (act_d >> 1));
    pstart_d = (cnt_d == '0);
    bypass_d = (act_d == ONE);
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= RST_CN;
      act_q    <= RST_N;
      pend_q   <= '0;
      busy_q   <= 1'b0;
      clkdiv_q <= 1'b0;
      pstart_q <= 1'b0;
      bypass_q <= (RESET_RATIO == 1);
    end else begin
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      pend_q   <= pend_d;
      busy_q   <= busy_d;
      clkdiv_q <= clkdiv_d;
      pstart_q <= pstart_d;
      bypass_q <= bypass_d;
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic neg_q;

  // stretches the high phase by half a cycle for odd N >= 3
  always_ff @(negedge clkin or negedge rst_n) begin
    if (!rst_n)
      neg_q <= 1'b0;
    else
      neg_q <= clkdiv_q & act_q[0] & ~bypass_q;
  end

  assign div_if.clkdiv = clkdiv_q | neg_q;
`else
  assign div_if.clkdiv = clkdiv_q;
`endif

  assign div_if.div_busy     = busy_q;
  assign div_if.div_active   = act_q;
  assign div_if.bypass       = bypass_q;
  assign div_if.period_start = pstart_q;

endmodule
